dmi_jtag_tap: RTL and testbench

- IEEE 1149.1 TAP controller sitting directly upstream of the DMI JTAG front end (DTM), in the tck_i domain.
- Decodes tms_i into the 16-state TAP FSM and holds a 5-bit IR.
- Implements the BYPASS, IDCODE and DTMCS data registers.
- Exports capture/shift/update strobes, DMI select, DTMCS select and a dmireset pulse to the DTM. Multiplexes the DTM's serial output onto td_o.

---
 rtl/dmi_jtag_tap.sv | 145 ++++++++++++++
 tb/tb_dmi_jtag_tap.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_tap.sv
// IEEE 1149.1 TAP controller in front of the DMI DTM: 16-state FSM, 5-bit IR,
// BYPASS/IDCODE/DTMCS data registers and the strobes the DTM needs.
module dmi_jtag_tap #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    input  logic       td_i,
    output logic       td_o,
    output logic       tdo_oe_o,
    input  logic       testmode_i,
    output logic       test_logic_reset_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_dr_o,
    output logic       dmi_access_o,
    output logic       dtmcs_select_o,
    output logic       dmi_reset_o,
    input  logic [1:0] dmi_error_i,
    output logic       dmi_tdi_o,
    input  logic       dmi_tdo_i
);

    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr,
        Exit2Dr, UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir,
        UpdateIr
    } tap_state_e;

    localparam logic [IrLength-1:0] IrIdcode    = 5'h01;
    localparam logic [IrLength-1:0] IrDtmcs     = 5'h10;
    localparam logic [IrLength-1:0] IrDmiAccess = 5'h11;
    localparam logic [IrLength-1:0] IrCapture   = 5'b00101;

    tap_state_e          state_q;
    logic [IrLength-1:0] ir_shift_q, ir_q;
    logic                bypass_q;
    logic [31:0]         idcode_q, dtmcs_q, dtmcs_cap;
    logic                idcode_sel;
    logic                unused_testmode;

    assign unused_testmode = testmode_i;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= TestLogicReset;
        end else begin
            unique case (state_q)
                TestLogicReset: state_q <= tms_i ? TestLogicReset : RunTestIdle;
                RunTestIdle:    state_q <= tms_i ? SelectDrScan   : RunTestIdle;
                SelectDrScan:   state_q <= tms_i ? SelectIrScan   : CaptureDr;
                CaptureDr:      state_q <= tms_i ? Exit1Dr        : ShiftDr;
                ShiftDr:        state_q <= tms_i ? Exit1Dr        : ShiftDr;
                Exit1Dr:        state_q <= tms_i ? UpdateDr       : PauseDr;
                PauseDr:        state_q <= tms_i ? Exit2Dr        : PauseDr;
                Exit2Dr:        state_q <= tms_i ? UpdateDr       : ShiftDr;
                UpdateDr:       state_q <= tms_i ? SelectDrScan   : RunTestIdle;
                SelectIrScan:   state_q <= tms_i ? TestLogicReset : CaptureIr;
                CaptureIr:      state_q <= tms_i ? Exit1Ir        : ShiftIr;
                ShiftIr:        state_q <= tms_i ? Exit1Ir        : ShiftIr;
                Exit1Ir:        state_q <= tms_i ? UpdateIr       : PauseIr;
                PauseIr:        state_q <= tms_i ? Exit2Ir        : PauseIr;
                Exit2Ir:        state_q <= tms_i ? UpdateIr       : ShiftIr;
                UpdateIr:       state_q <= tms_i ? SelectDrScan   : RunTestIdle;
                default:        state_q <= TestLogicReset;
            endcase
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_shift_q <= '0;
            ir_q       <= IrIdcode;
        end else begin
            case (state_q)
                TestLogicReset: ir_q       <= IrIdcode;
                CaptureIr:      ir_shift_q <= IrCapture;
                ShiftIr:        ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};
                UpdateIr:       ir_q       <= ir_shift_q;
                default:        ;
            endcase
        end
    end

    assign idcode_sel     = (ir_q == IrIdcode);
    assign dtmcs_select_o = (ir_q == IrDtmcs);
    assign dmi_access_o   = (ir_q == IrDmiAccess);

    // dmihardreset, dmireset and bit 15 always capture as zero
    assign dtmcs_cap = {14'h0, 1'b0, 1'b0, 1'b0, 3'd1, dmi_error_i, 6'd7, 4'd1};

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            bypass_q <= 1'b0;
            idcode_q <= IdcodeValue;
            dtmcs_q  <= '0;
        end else begin
            if (state_q == CaptureDr) begin
                bypass_q <= 1'b0;
                if (idcode_sel)     idcode_q <= IdcodeValue;
                if (dtmcs_select_o) dtmcs_q  <= dtmcs_cap;
            end else if (state_q == ShiftDr) begin
                bypass_q <= td_i;
                if (idcode_sel)     idcode_q <= {td_i, idcode_q[31:1]};
                if (dtmcs_select_o) dtmcs_q  <= {td_i, dtmcs_q[31:1]};
            end
        end
    end

    // TDO changes on the falling edge so the host samples a stable bit on the rising edge
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            td_o     <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            case (state_q)
                ShiftIr: begin
                    td_o     <= ir_shift_q[0];
                    tdo_oe_o <= 1'b1;
                end
                ShiftDr: begin
                    tdo_oe_o <= 1'b1;
                    if (idcode_sel)          td_o <= idcode_q[0];
                    else if (dtmcs_select_o) td_o <= dtmcs_q[0];
                    else if (dmi_access_o)   td_o <= dmi_tdo_i;
                    else                     td_o <= bypass_q;
                end
                default: begin
                    td_o     <= 1'b0;
                    tdo_oe_o <= 1'b0;
                end
            endcase
        end
    end

    assign test_logic_reset_o = (state_q == TestLogicReset);
    assign shift_dr_o         = (state_q == ShiftDr);
    assign update_dr_o        = (state_q == UpdateDr);
    assign capture_dr_o       = (state_q == CaptureDr);
    assign dmi_reset_o        = (state_q == UpdateDr) && dtmcs_select_o && dtmcs_q[16];
    assign dmi_tdi_o          = td_i;

endmodule

// File: tb/tb_dmi_jtag_tap.sv
// Bench for dmi_jtag_tap: drives whole IR/DR scans and predicts each scan's TDO stream,
// strobe counts and dmireset pulses from the register semantics alone.
module tb_dmi_jtag_tap;

    localparam logic [31:0] IdcodeValue = 32'h4A5C_3E1B;

    logic       tck_i = 1'b0;
    logic       trst_ni = 1'b1;
    logic       tms_i = 1'b1, td_i = 1'b0, testmode_i = 1'b0, dmi_tdo_i = 1'b0;
    logic [1:0] dmi_error_i = 2'd0;
    logic       td_o, tdo_oe_o, test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o;
    logic       dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o;

    dmi_jtag_tap #(.IrLength(5), .IdcodeValue(IdcodeValue)) dut (
        .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
        .tdo_oe_o(tdo_oe_o), .testmode_i(testmode_i), .test_logic_reset_o(test_logic_reset_o),
        .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o), .capture_dr_o(capture_dr_o),
        .dmi_access_o(dmi_access_o), .dtmcs_select_o(dtmcs_select_o),
        .dmi_reset_o(dmi_reset_o), .dmi_error_i(dmi_error_i), .dmi_tdi_o(dmi_tdi_o),
        .dmi_tdo_i(dmi_tdo_i)
    );

    initial forever #5 tck_i = ~tck_i;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1);
    end

    int n_cmp = 0, n_bad = 0;
    logic [4:0] m_ir = 5'h01;
    logic so, soe, s_sdr;
    int cnt_oe, cnt_sdr, cnt_cap, cnt_upd, cnt_rst, cnt_rst_bad, cnt_zero_bad, cnt_tdi_bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dtmcs_word(input logic [1:0] err);
        return {14'h0, 3'b000, 3'd1, err, 6'd7, 4'd1};
    endfunction

    task automatic clr_counts();
        cnt_oe = 0; cnt_sdr = 0; cnt_cap = 0; cnt_upd = 0; cnt_rst = 0;
        cnt_rst_bad = 0; cnt_zero_bad = 0; cnt_tdi_bad = 0;
    endtask

    // One TCK: outputs are sampled after the falling edge, i.e. in the pre-transition state
    task automatic step(input logic tms, input logic tdi, input logic dtdo);
        tms_i = tms; td_i = tdi; dmi_tdo_i = dtdo;
        @(negedge tck_i); #1;
        so = td_o; soe = tdo_oe_o; s_sdr = shift_dr_o;
        if (soe) cnt_oe++;
        if (s_sdr) cnt_sdr++;
        if (capture_dr_o) cnt_cap++;
        if (update_dr_o) cnt_upd++;
        if (dmi_reset_o) begin
            cnt_rst++;
            if (!update_dr_o || !dtmcs_select_o) cnt_rst_bad++;
        end
        if (!soe && so !== 1'b0) cnt_zero_bad++;
        if (dmi_tdi_o !== td_i) cnt_tdi_bad++;
        @(posedge tck_i); #1;
    endtask

    task automatic pause_seq();
        int k;
        k = $urandom_range(0, 3);
        step(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic ir_scan(input logic [4:0] v, input int pause_at);
        logic [4:0] dout;
        logic last, pz;
        dout = '0;
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            last = (i == 4);
            pz = (i == pause_at) && !last;
            step(last || pz, v[i], 1'b0);
            dout[i] = so;
            if (pz) pause_seq();
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        m_ir = v;
        check_eq($sformatf("ir_capture v=%0h", v), 64'(dout), 64'h05);
        check_eq("ir_oe_count", 64'(cnt_oe), 64'd5);
        check_eq("ir_dr_strobes", 64'(cnt_cap + cnt_upd + cnt_sdr + cnt_rst), 64'd0);
        check_eq("ir_dmi_access", 64'(dmi_access_o), 64'(m_ir == 5'h11));
        check_eq("ir_dtmcs_select", 64'(dtmcs_select_o), 64'(m_ir == 5'h10));
    endtask

    task automatic dr_scan(input int len, input logic [63:0] din, input int pause_at,
                           output logic [63:0] dout);
        logic [63:0] dtdo, exp, mask;
        logic [95:0] s;
        logic last, pz, exp_rst;
        dtdo = {$urandom, $urandom};
        dout = '0;
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(len == 0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            pz = (i == pause_at) && !last;
            step(last || pz, din[i], dtdo[i]);
            dout[i] = so;
            if (pz) pause_seq();
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        mask = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
        s = {din, dtmcs_word(dmi_error_i)};
        exp_rst = (m_ir == 5'h10) && s[16 + len];
        case (m_ir)
            5'h01: begin
                s = {din, IdcodeValue};
                exp = s[63:0];
            end
            5'h10: exp = s[63:0];
            5'h11: exp = dtdo;
            default: exp = {din[62:0], 1'b0};
        endcase
        check_eq($sformatf("dr_out ir=%0h len=%0d", m_ir, len), dout, exp & mask);
        check_eq("dr_oe_count", 64'(cnt_oe), 64'(len));
        check_eq("dr_shift_count", 64'(cnt_sdr), 64'(len));
        check_eq("dr_capture_count", 64'(cnt_cap), 64'd1);
        check_eq("dr_update_count", 64'(cnt_upd), 64'd1);
        check_eq($sformatf("dmi_reset_pulses ir=%0h", m_ir), 64'(cnt_rst), 64'(exp_rst));
        check_eq("dmi_reset_stray", 64'(cnt_rst_bad), 64'd0);
        check_eq("tdo_idle_zero", 64'(cnt_zero_bad), 64'd0);
        check_eq("dmi_tdi_fwd", 64'(cnt_tdi_bad), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tlr"}, 64'(test_logic_reset_o), 64'd1);
        check_eq({tag, "_strobes"}, 64'({shift_dr_o, update_dr_o, capture_dr_o, dmi_reset_o}),
                 64'd0);
        check_eq({tag, "_ir_sel"}, 64'({dmi_access_o, dtmcs_select_o}), 64'd0);
    endtask

    logic [63:0] d;
    logic [4:0]  ir_pick;
    int          len;

    initial begin
        #2 trst_ni = 1'b0;
        repeat (2) @(posedge tck_i);
        #1;
        check_reset_outputs("reset");
        check_eq("reset_tdo", 64'({td_o, tdo_oe_o}), 64'd0);
        trst_ni = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // IDCODE straight out of reset, then longer than 32 to see TDI come back out
        dr_scan(32, {$urandom, $urandom}, -1, d);
        check_eq("idcode_word", d[31:0], 64'(IdcodeValue));
        dr_scan(40, {$urandom, $urandom}, 10, d);

        // six TMS=1 from ShiftDr land in TestLogicReset with IR back at IDCODE
        ir_scan(5'h11, -1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        check_reset_outputs("tms_reset");
        m_ir = 5'h01;
        step(1'b0, 1'b0, 1'b0);
        dr_scan(32, 64'd0, -1, d);

        // DTMCS capture with dmistat = 3
        ir_scan(5'h10, 2);
        dmi_error_i = 2'd3;
        dr_scan(32, 64'h0001_0000, -1, d);
        check_eq("dtmcs_word", d[31:0], 64'h0000_1C71);
        dr_scan(32, 64'd0, -1, d);
        dr_scan(0, 64'd0, -1, d);

        // unknown instruction behaves as BYPASS
        ir_scan(5'h07, -1);
        dr_scan(3, 64'b011, -1, d);
        check_eq("bypass_bits", d[2:0], 64'b110);

        // DMI access echoes dmi_tdo_i
        ir_scan(5'h11, -1);
        dr_scan(41, {$urandom, $urandom}, 20, d);

        // asynchronous reset in the middle of an IR shift
        ir_scan(5'h10, -1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        trst_ni = 1'b0;
        #2;
        check_reset_outputs("trst_mid_shift");
        @(negedge tck_i); #1;
        check_eq("trst_tdo", 64'({td_o, tdo_oe_o}), 64'd0);
        @(posedge tck_i); #1;
        trst_ni = 1'b1;
        m_ir = 5'h01;
        step(1'b0, 1'b0, 1'b0);
        dr_scan(32, {$urandom, $urandom}, 5, d);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: ir_pick = 5'h01;
                1: ir_pick = 5'h10;
                2: ir_pick = 5'h11;
                3: ir_pick = 5'h1F;
                default: ir_pick = 5'($urandom);
            endcase
            ir_scan(ir_pick, $urandom_range(0, 5) - 1);
            dmi_error_i = 2'($urandom);
            len = (ir_pick == 5'h10 && $urandom_range(0, 1) == 1) ? 32 : $urandom_range(0, 60);
            dr_scan(len, {$urandom, $urandom}, int'($urandom_range(0, 60)) - 1, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
